// File: rtl/head_table_sb.sv
// Bucket head-pointer table: lookup with pass-through payload, modify scoreboard,
// write snooping on every pipeline stage and a restartable clear engine.
module head_table_sb #(
  parameter int BUCKET_WIDTH = 8,
  parameter int PTR_WIDTH    = 10,
  parameter int PDATA_WIDTH  = 64,
  parameter int RD_LATENCY   = 1,
  parameter int SB_DEPTH     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [PDATA_WIDTH-1:0]  pdata_in_i,
  input  logic [BUCKET_WIDTH-1:0] bucket_in_i,
  input  logic                    modify_in_i,
  input  logic                    pdata_in_valid_i,
  output logic                    pdata_in_ready_o,
  output logic [PDATA_WIDTH-1:0]  pdata_out_o,
  output logic [BUCKET_WIDTH-1:0] bucket_out_o,
  output logic [PTR_WIDTH-1:0]    head_ptr_o,
  output logic                    head_ptr_val_o,
  output logic                    pdata_out_valid_o,
  input  logic                    pdata_out_ready_i,
  input  logic                    wr_en_i,
  input  logic [BUCKET_WIDTH-1:0] wr_addr_i,
  input  logic [PTR_WIDTH-1:0]    wr_ptr_i,
  input  logic                    wr_ptr_val_i,
  input  logic                    op_done_i,
  input  logic [BUCKET_WIDTH-1:0] op_done_bucket_i,
  input  logic                    clear_run_i,
  output logic                    clear_busy_o,
  output logic                    clear_done_o,
  output logic                    sb_full_o
);

  localparam int DEPTH = 1 << BUCKET_WIDTH;
  localparam int HW    = PTR_WIDTH + 1;

  function automatic logic [HW-1:0] f_snoop(input logic we, input logic [BUCKET_WIDTH-1:0] waddr,
                                           input logic [HW-1:0] wdata, input logic [BUCKET_WIDTH-1:0] bkt,
                                           input logic [HW-1:0] cur);
    return (we && (waddr == bkt)) ? wdata : cur;
  endfunction

  logic [HW-1:0]           r_mem [DEPTH];
  logic                    r_clr_busy;
  logic [BUCKET_WIDTH-1:0] r_clr_cnt;
  logic                    w_we;
  logic [BUCKET_WIDTH-1:0] w_waddr;
  logic [HW-1:0]           w_wdata;
  logic                    w_adv, w_acc, w_hazard, w_sb_hit;
  logic                    w_out_vld;
  logic [PDATA_WIDTH-1:0]  w_out_pdata;
  logic [BUCKET_WIDTH-1:0] w_out_bkt;
  logic [HW-1:0]           w_out_head;

  // While clearing, the clear engine owns the write port and external writes are dropped.
  assign w_we    = r_clr_busy | wr_en_i;
  assign w_waddr = r_clr_busy ? r_clr_cnt : wr_addr_i;
  assign w_wdata = r_clr_busy ? '0 : {wr_ptr_val_i, wr_ptr_i};

  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_clr_busy <= 1'b0;
      r_clr_cnt  <= '0;
    end else if (clear_run_i) begin
      r_clr_busy <= 1'b1;
      r_clr_cnt  <= '0;
    end else if (r_clr_busy) begin
      r_clr_cnt <= r_clr_cnt + BUCKET_WIDTH'(1);
      if (r_clr_cnt == '1) r_clr_busy <= 1'b0;
    end
  end

  assign clear_busy_o = r_clr_busy;
  assign clear_done_o = r_clr_busy && (r_clr_cnt == '1);

  // Scoreboard of in-flight modify ops
  logic [SB_DEPTH-1:0]     r_sb_vld;
  logic [BUCKET_WIDTH-1:0] r_sb_bkt [SB_DEPTH];
  logic [SB_DEPTH-1:0]     w_sb_nxt, w_alloc_oh;
  logic                    w_freed, w_alloced;

  always_comb begin
    w_sb_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (r_sb_vld[i] && (r_sb_bkt[i] == bucket_in_i)) w_sb_hit = 1'b1;
  end

  assign w_hazard         = w_sb_hit || (modify_in_i && (&r_sb_vld));
  assign w_adv            = !w_out_vld || pdata_out_ready_i;
  assign pdata_in_ready_o = rst_n_i && !r_clr_busy && w_adv && !w_hazard;
  assign w_acc            = pdata_in_valid_i && pdata_in_ready_o;
  assign sb_full_o        = &r_sb_vld;

  // Flush happens before allocation so an op accepted alongside clear_run stays tracked.
  always_comb begin
    w_sb_nxt   = r_sb_vld;
    w_alloc_oh = '0;
    w_freed    = 1'b0;
    w_alloced  = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (!w_freed && op_done_i && r_sb_vld[i] && (r_sb_bkt[i] == op_done_bucket_i)) begin
        w_sb_nxt[i] = 1'b0;
        w_freed     = 1'b1;
      end
    if (clear_run_i) w_sb_nxt = '0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (!w_alloced && w_acc && modify_in_i && (clear_run_i || !r_sb_vld[i])) begin
        w_alloc_oh[i] = 1'b1;
        w_alloced     = 1'b1;
      end
    w_sb_nxt = w_sb_nxt | w_alloc_oh;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_sb_vld <= '0;
    else          r_sb_vld <= w_sb_nxt;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SB_DEPTH; i++)
      if (w_alloc_oh[i]) r_sb_bkt[i] <= bucket_in_i;
  end

  // Stage 1: RAM read register; a same-cycle write to the read address is forwarded.
  logic                    r_s1_vld;
  logic [PDATA_WIDTH-1:0]  r_s1_pdata;
  logic [BUCKET_WIDTH-1:0] r_s1_bkt;
  logic [HW-1:0]           r_s1_head;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   r_s1_vld <= 1'b0;
    else if (w_adv) r_s1_vld <= w_acc;
  end

  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_s1_pdata <= pdata_in_i;
      r_s1_bkt   <= bucket_in_i;
      r_s1_head  <= f_snoop(w_we, w_waddr, w_wdata, bucket_in_i, r_mem[bucket_in_i]);
    end else begin
      r_s1_head  <= f_snoop(w_we, w_waddr, w_wdata, r_s1_bkt, r_s1_head);
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      // Stage 2: optional output register, also snooped while held.
      logic                    r_s2_vld;
      logic [PDATA_WIDTH-1:0]  r_s2_pdata;
      logic [BUCKET_WIDTH-1:0] r_s2_bkt;
      logic [HW-1:0]           r_s2_head;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   r_s2_vld <= 1'b0;
        else if (w_adv) r_s2_vld <= r_s1_vld;
      end

      always_ff @(posedge clk_i) begin
        if (w_adv) begin
          r_s2_pdata <= r_s1_pdata;
          r_s2_bkt   <= r_s1_bkt;
          r_s2_head  <= f_snoop(w_we, w_waddr, w_wdata, r_s1_bkt, r_s1_head);
        end else begin
          r_s2_head  <= f_snoop(w_we, w_waddr, w_wdata, r_s2_bkt, r_s2_head);
        end
      end

      assign w_out_vld   = r_s2_vld;
      assign w_out_pdata = r_s2_pdata;
      assign w_out_bkt   = r_s2_bkt;
      assign w_out_head  = r_s2_head;
    end else begin : g_lat1
      assign w_out_vld   = r_s1_vld;
      assign w_out_pdata = r_s1_pdata;
      assign w_out_bkt   = r_s1_bkt;
      assign w_out_head  = r_s1_head;
    end
  endgenerate

  assign pdata_out_valid_o = w_out_vld;
  assign pdata_out_o       = w_out_pdata;
  assign bucket_out_o      = w_out_bkt;
  assign head_ptr_o        = w_out_head[PTR_WIDTH-1:0];
  assign head_ptr_val_o    = w_out_vld & w_out_head[PTR_WIDTH];

endmodule

// File: doc/head_table_sb.md
Name: head_table_sb

Overview:
- Parametrised successor of the bucket head-pointer table. It sits in the hash-table pipeline between the bucket-hash stage and the chain-walk stage.
- Looks up the head pointer of a bucket and passes the opaque pipeline data along with it.
- Replaces the old one-entry "previous op" backpressure with a multi-entry modify scoreboard that is released explicitly by downstream.
- Keeps every in-flight lookup coherent with head writes through per-stage write snooping.
- Adds selectable read latency and a restartable clear engine.

Parameters:
BUCKET_WIDTH  8   bucket address width; table depth is 2**BUCKET_WIDTH
PTR_WIDTH     10  head pointer width
PDATA_WIDTH   64  opaque pass-through payload width
RD_LATENCY    1   accept-to-output latency; legal values are 1 and 2 (2 adds an output register stage)
SB_DEPTH      4   maximum number of in-flight modify ops (insert/delete)

Ports:
clk_i                 in   1             clock
rst_n_i               in   1             asynchronous active-low reset
pdata_in_i            in   PDATA_WIDTH   payload
bucket_in_i           in   BUCKET_WIDTH  bucket to look up
modify_in_i           in   1             1 = insert/delete, 0 = search
pdata_in_valid_i      in   1             input valid
pdata_in_ready_o      out  1             input ready
pdata_out_o           out  PDATA_WIDTH   payload
bucket_out_o          out  BUCKET_WIDTH  bucket
head_ptr_o            out  PTR_WIDTH     head pointer
head_ptr_val_o        out  1             head pointer valid
pdata_out_valid_o     out  1             output valid
pdata_out_ready_i     in   1             output ready
wr_en_i               in   1             head write strobe
wr_addr_i             in   BUCKET_WIDTH  write bucket
wr_ptr_i              in   PTR_WIDTH     write pointer
wr_ptr_val_i          in   1             write pointer-valid
op_done_i             in   1             modify op retired downstream
op_done_bucket_i      in   BUCKET_WIDTH  bucket of the retired op
clear_run_i           in   1             start/restart clear (pulse)
clear_busy_o          out  1             clear in progress
clear_done_o          out  1             one-cycle pulse on the last clear write
sb_full_o             out  1             scoreboard full

Behaviour:
- Reset (rst_n_i low, asynchronous): all valids 0, pdata_in_ready_o 0, clear_busy_o 0, clear_done_o 0, scoreboard empty, sb_full_o 0. RAM contents are not reset.
- Handshake is valid/ready. Data transfers on valid && ready.
- A transfer accepted at cycle t appears on the output at t+RD_LATENCY when the path is unblocked.
- The pipeline is stall-all: if pdata_out_valid_o && !pdata_out_ready_i, every stage holds, the RAM read enable is deasserted and the stored read data is kept.
- Output signals must stay stable while valid && !ready.
- pdata_in_ready_o = !clear_busy_o && pipeline_can_advance && !hazard.
- hazard = bucket_in_i matches any live scoreboard entry, OR (modify_in_i && scoreboard full).
- The hazard applies to searches and modifies alike. Ready may depend combinationally on bucket_in_i and modify_in_i.
- Scoreboard:
  - SB_DEPTH entries, each holding a valid bit and a bucket.
  - An accepted modify op allocates the lowest free entry.
  - op_done_i frees exactly one live entry matching op_done_bucket_i (the lowest index if several match). op_done_i with no match is ignored.
  - Allocate and free in the same cycle are both performed. A free takes effect for the hazard check in the next cycle.
  - sb_full_o is asserted when all entries are live.
- Write snooping:
  - Each pipeline stage, including the output register, holds head_ptr and head_ptr_val.
  - In any cycle with an effective write whose address equals the stage bucket, the stage value is replaced with the write data.
  - The RAM is read-old on a same-address read/write collision; snooping covers that case.
  - Guarantee: the emitted head equals the RAM content after all writes up to the cycle before the output handshake.
- Clear:
  - clear_run_i sets clear_busy_o and starts the address counter at 0, including when a clear is already running (restart).
  - While busy, one address is written per cycle with ptr=0 and val=0. The counter wraps at 2**BUCKET_WIDTH.
  - clear_done_o pulses in the cycle that writes address all-ones; clear_busy_o drops in the next cycle.
  - clear_run_i also flushes the scoreboard.
  - While busy, wr_en_i is ignored (dropped) and input ready is 0.
  - In-flight pipeline entries keep draining; they snoop the clear writes and therefore emit ptr=0, val=0.
- An accepted op that hits a hazard never occurs, because hazard blocks ready.

Test Plan:
- Reset release: with no stimulus, ready=1 on the first cycle after rst_n_i rises and out_valid=0. Write bucket 5 (ptr=0x2A, val=1), then search bucket 5 -> output head 0x2A/1 at t+RD_LATENCY, for both RD_LATENCY=1 and RD_LATENCY=2.
- Hazard: accept modify on bucket 3, then present search on bucket 3 -> ready=0. Pulse op_done_i with bucket 3 -> ready=1 the next cycle. Search on bucket 4 is accepted during the hold.
- Scoreboard full: 4 modifies on buckets 1..4 -> sb_full_o=1 and a 5th modify on bucket 9 stalls. A search on bucket 9 is still accepted. op_done_i on bucket 2 -> the modify proceeds.
- Snoop under backpressure: search bucket 7 (RAM 0x10/1) with out_ready=0 for 5 cycles. Write bucket 7 = 0x33/1 in cycle 3 -> emitted head is 0x33/1. A collision write in the accept cycle is also forwarded.
- Clear: BUCKET_WIDTH=4, clear_run_i pulse -> busy for 16 cycles, done pulses on the 16th, and all buckets read 0/0 afterwards. A clear_run_i at cycle 8 restarts the count: 8+16 cycles in total. wr_en_i during the clear is dropped.
- Async reset mid-traffic: assert rst_n_i with the pipeline full and the scoreboard at 3 entries -> outputs invalid immediately and the scoreboard is empty after release.
